// File: rtl/mem_lsu_stage.sv
// Memory/load-store pipeline stage: registers the execute slot, tracks the data-memory
// response for loads, and aligns/extends load data for writeback and forwarding.
module mem_lsu_stage #(
   parameter int DW     = 32,
   parameter int RF_AW  = 5,
   parameter bit FWD_EN = 1,
   localparam int LW    = $clog2(DW/8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              in_valid,
   input  logic [31:0]       in_pc,
   input  logic              in_ld,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_signed,
   input  logic [LW-1:0]     in_addr_lo,
   input  logic              in_rf_we,
   input  logic [RF_AW-1:0]  in_rf_waddr,
   input  logic [DW-1:0]     in_ex_result,
   input  logic              in_hilo_we,
   input  logic [2*DW-1:0]   in_hilo,
   input  logic [DW-1:0]     dmem_rdata,
   input  logic              dmem_rvalid,
   output logic              wb_valid,
   output logic [31:0]       wb_pc,
   output logic              wb_rf_we,
   output logic [RF_AW-1:0]  wb_rf_waddr,
   output logic [DW-1:0]     wb_rf_wdata,
   output logic              wb_hilo_we,
   output logic [2*DW-1:0]   wb_hilo,
   output logic              wb_misalign,
   output logic              mem_stall_req,
   output logic              fwd_rf_we,
   output logic [RF_AW-1:0]  fwd_rf_waddr,
   output logic [DW-1:0]     fwd_rf_wdata,
   output logic              fwd_hilo_we,
   output logic [2*DW-1:0]   fwd_hilo
);

   typedef enum logic [1:0] {IDLE, WAIT, HAVE} ld_state_e;

   typedef struct packed {
      logic              valid;
      logic [31:0]       pc;
      logic              ld;
      logic [1:0]        size;
      logic              sgn;
      logic [LW-1:0]     addr;
      logic              rf_we;
      logic [RF_AW-1:0]  waddr;
      logic [DW-1:0]     res;
      logic              hilo_we;
      logic [2*DW-1:0]   hilo;
   } stage_t;

   stage_t            stage_q, stage_d;
   ld_state_e         state_q, state_d;
   logic [DW-1:0]     buf_q, buf_d;

   logic              unused_stall;
   assign unused_stall = ^{stall[5], stall[2:0]};

   always_comb begin
      stage_d = stage_q;
      if (!stall[3]) begin
         stage_d = '{valid: in_valid, pc: in_pc, ld: in_ld, size: in_ld_size,
                     sgn: in_ld_signed, addr: in_addr_lo, rf_we: in_rf_we,
                     waddr: in_rf_waddr, res: in_ex_result, hilo_we: in_hilo_we,
                     hilo: in_hilo};
      end else if (!stall[4]) begin
         stage_d = '0;
      end
   end

   // Response data is captured either alongside the load entering the stage or while
   // waiting; a response in any other situation is dropped.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      if (!stall[3]) begin
         if (in_valid && in_ld) begin
            if (dmem_rvalid) begin
               state_d = HAVE;
               buf_d   = dmem_rdata;
            end else begin
               state_d = WAIT;
            end
         end else begin
            state_d = IDLE;
         end
      end else if (!stall[4]) begin
         state_d = IDLE;
      end else if (state_q == WAIT && dmem_rvalid) begin
         state_d = HAVE;
         buf_d   = dmem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stage_q <= '0;
         state_q <= IDLE;
         buf_q   <= '0;
      end else begin
         stage_q <= stage_d;
         state_q <= state_d;
         buf_q   <= buf_d;
      end
   end

   assign mem_stall_req = stage_q.valid && stage_q.ld && (state_q == WAIT) && !dmem_rvalid;

   logic [1:0]      eff_size;
   int unsigned     nbits;
   logic [LW-1:0]   off;
   logic [DW-1:0]   raw, shifted, mask, ld_data;
   logic            sign_bit;

   always_comb begin
      eff_size = stage_q.size;
      if (DW == 32 && stage_q.size == 2'd3) eff_size = 2'd2;
      nbits    = 32'd8 << eff_size;
      off      = stage_q.addr & ~LW'((nbits / 8) - 1);
      raw      = (state_q == WAIT && dmem_rvalid) ? dmem_rdata : buf_q;
      shifted  = raw >> {off, 3'b000};
      mask     = (nbits >= DW) ? '1 : ((DW'(1) << nbits) - DW'(1));
      sign_bit = |(shifted & (DW'(1) << (nbits - 1)));
      ld_data  = shifted & mask;
      if (stage_q.sgn && sign_bit) ld_data = ld_data | ~mask;
   end

   assign wb_valid    = stage_q.valid & ~mem_stall_req;
   assign wb_pc       = stage_q.pc;
   assign wb_rf_we    = stage_q.rf_we & ~mem_stall_req;
   assign wb_rf_waddr = stage_q.waddr;
   assign wb_rf_wdata = (stage_q.valid && stage_q.ld) ? ld_data : stage_q.res;
   assign wb_hilo_we  = stage_q.hilo_we & ~mem_stall_req;
   assign wb_hilo     = stage_q.hilo;
   assign wb_misalign = stage_q.valid && stage_q.ld &&
                        ((stage_q.addr & LW'((nbits / 8) - 1)) != '0);

   assign fwd_rf_we    = FWD_EN ? wb_rf_we    : 1'b0;
   assign fwd_rf_waddr = FWD_EN ? wb_rf_waddr : '0;
   assign fwd_rf_wdata = FWD_EN ? wb_rf_wdata : '0;
   assign fwd_hilo_we  = FWD_EN ? wb_hilo_we  : 1'b0;
   assign fwd_hilo     = FWD_EN ? wb_hilo     : '0;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: a 32-bit and a 64-bit instance driven with
// hand-computed load/stall/reset scenarios.
module tb_mem_lsu_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;

   // 32-bit instance signals
   logic [5:0]   a_stall;
   logic         a_valid, a_ld, a_sgn, a_we, a_hwe, a_rvalid;
   logic [31:0]  a_pc, a_exr, a_rdata;
   logic [1:0]   a_size, a_addr;
   logic [4:0]   a_waddr;
   logic [63:0]  a_hilo;
   logic         a_wb_valid, a_wb_we, a_wb_hwe, a_mis, a_sreq, a_f_we, a_f_hwe;
   logic [31:0]  a_wb_pc, a_wb_wdata, a_f_wdata;
   logic [4:0]   a_wb_waddr, a_f_waddr;
   logic [63:0]  a_wb_hilo, a_f_hilo;

   // 64-bit instance signals
   logic [5:0]   b_stall;
   logic         b_valid, b_ld, b_sgn, b_we, b_hwe, b_rvalid;
   logic [31:0]  b_pc, b_wb_pc;
   logic [63:0]  b_exr, b_rdata, b_wb_wdata, b_f_wdata;
   logic [1:0]   b_size;
   logic [2:0]   b_addr;
   logic [4:0]   b_waddr, b_wb_waddr, b_f_waddr;
   logic [127:0] b_hilo, b_wb_hilo, b_f_hilo;
   logic         b_wb_valid, b_wb_we, b_wb_hwe, b_mis, b_sreq, b_f_we, b_f_hwe;

   mem_lsu_stage #(.DW(32), .RF_AW(5), .FWD_EN(1)) u_a (
      .clk(clk), .rst(rst), .stall(a_stall), .in_valid(a_valid), .in_pc(a_pc),
      .in_ld(a_ld), .in_ld_size(a_size), .in_ld_signed(a_sgn), .in_addr_lo(a_addr),
      .in_rf_we(a_we), .in_rf_waddr(a_waddr), .in_ex_result(a_exr),
      .in_hilo_we(a_hwe), .in_hilo(a_hilo), .dmem_rdata(a_rdata), .dmem_rvalid(a_rvalid),
      .wb_valid(a_wb_valid), .wb_pc(a_wb_pc), .wb_rf_we(a_wb_we), .wb_rf_waddr(a_wb_waddr),
      .wb_rf_wdata(a_wb_wdata), .wb_hilo_we(a_wb_hwe), .wb_hilo(a_wb_hilo),
      .wb_misalign(a_mis), .mem_stall_req(a_sreq), .fwd_rf_we(a_f_we),
      .fwd_rf_waddr(a_f_waddr), .fwd_rf_wdata(a_f_wdata), .fwd_hilo_we(a_f_hwe),
      .fwd_hilo(a_f_hilo)
   );

   mem_lsu_stage #(.DW(64), .RF_AW(5), .FWD_EN(1)) u_b (
      .clk(clk), .rst(rst), .stall(b_stall), .in_valid(b_valid), .in_pc(b_pc),
      .in_ld(b_ld), .in_ld_size(b_size), .in_ld_signed(b_sgn), .in_addr_lo(b_addr),
      .in_rf_we(b_we), .in_rf_waddr(b_waddr), .in_ex_result(b_exr),
      .in_hilo_we(b_hwe), .in_hilo(b_hilo), .dmem_rdata(b_rdata), .dmem_rvalid(b_rvalid),
      .wb_valid(b_wb_valid), .wb_pc(b_wb_pc), .wb_rf_we(b_wb_we), .wb_rf_waddr(b_wb_waddr),
      .wb_rf_wdata(b_wb_wdata), .wb_hilo_we(b_wb_hwe), .wb_hilo(b_wb_hilo),
      .wb_misalign(b_mis), .mem_stall_req(b_sreq), .fwd_rf_we(b_f_we),
      .fwd_rf_waddr(b_f_waddr), .fwd_rf_wdata(b_f_wdata), .fwd_hilo_we(b_f_hwe),
      .fwd_hilo(b_f_hilo)
   );

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop_a();
      a_valid = 0; a_ld = 0; a_size = 0; a_sgn = 0; a_addr = 0; a_we = 0;
      a_waddr = 0; a_exr = 0; a_pc = 0; a_hwe = 0; a_hilo = 0;
   endtask

   task automatic issue_a(input logic ld, input logic [1:0] sz, input logic sgn,
                          input logic [1:0] ad, input logic [4:0] wa,
                          input logic [31:0] exr, input logic [31:0] pc);
      a_valid = 1; a_ld = ld; a_size = sz; a_sgn = sgn; a_addr = ad; a_we = 1;
      a_waddr = wa; a_exr = exr; a_pc = pc; a_hwe = 0; a_hilo = 0;
   endtask

   task automatic nop_b();
      b_valid = 0; b_ld = 0; b_size = 0; b_sgn = 0; b_addr = 0; b_we = 0;
      b_waddr = 0; b_exr = 0; b_pc = 0; b_hwe = 0; b_hilo = 0;
   endtask

   int scnt;

   initial begin
      rst = 0;
      nop_a(); a_stall = 0; a_rvalid = 0; a_rdata = 0;
      nop_b(); b_stall = 0; b_rvalid = 0; b_rdata = 0;
      tick(); tick();
      chk("rst_wb_valid", a_wb_valid, 0);
      chk("rst_wdata", a_wb_wdata, 0);
      chk("rst_pc", a_wb_pc, 0);
      chk("rst_stall_req", a_sreq, 0);
      chk("rst_fwd_we", a_f_we, 0);
      chk("rst_b_hilo", b_wb_hilo, 0);
      rst = 1;

      // lb signed, lane 3
      issue_a(1, 0, 1, 2'd3, 5'd5, 32'hDEAD, 32'h100);
      a_rdata = 32'h80FF_1234; a_rvalid = 1;
      tick();
      nop_a(); a_rvalid = 0; a_rdata = 0; #1;
      chk("lb_wdata", a_wb_wdata, 32'hFFFF_FF80);
      chk("lb_fwd_wdata", a_f_wdata, 32'hFFFF_FF80);
      chk("lb_valid", a_wb_valid, 1);
      chk("lb_mis", a_mis, 0);
      chk("lb_waddr", a_wb_waddr, 5);
      chk("lb_pc", a_wb_pc, 32'h100);

      // lbu
      issue_a(1, 0, 0, 2'd3, 5'd5, 32'hDEAD, 32'h104);
      a_rdata = 32'h80FF_1234; a_rvalid = 1;
      tick();
      nop_a(); a_rvalid = 0; a_rdata = 0; #1;
      chk("lbu_wdata", a_wb_wdata, 32'h0000_0080);

      // lh misaligned
      issue_a(1, 1, 1, 2'd1, 5'd6, 32'h0, 32'h108);
      a_rdata = 32'h1234_8765; a_rvalid = 1;
      tick();
      nop_a(); a_rvalid = 0; a_rdata = 0; #1;
      chk("lh_mis", a_mis, 1);
      chk("lh_wdata", a_wb_wdata, 32'hFFFF_8765);

      // dword on 32-bit datapath behaves as word
      issue_a(1, 3, 1, 2'd2, 5'd8, 32'h0, 32'h10C);
      a_rdata = 32'h89AB_CDEF; a_rvalid = 1;
      tick();
      nop_a(); a_rvalid = 0; a_rdata = 0; #1;
      chk("ld32_wdata", a_wb_wdata, 32'h89AB_CDEF);
      chk("ld32_mis", a_mis, 1);

      // response three cycles late
      issue_a(1, 2, 0, 2'd0, 5'd7, 32'h0, 32'h300);
      a_rvalid = 0;
      tick();
      nop_a(); a_stall = 6'b011111; scnt = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (a_sreq) scnt++;
         chk("late_sreq", a_sreq, 1);
         chk("late_we", a_wb_we, 0);
         chk("late_valid", a_wb_valid, 0);
         tick();
      end
      a_rvalid = 1; a_rdata = 32'hCAFE_BABE; a_stall = 0; #1;
      chk("late_sreq_done", a_sreq, 0);
      chk("late_stall_cycles", scnt, 3);
      chk("late_valid_done", a_wb_valid, 1);
      chk("late_we_done", a_wb_we, 1);
      chk("late_wdata", a_wb_wdata, 32'hCAFE_BABE);
      tick();
      a_rvalid = 0; a_rdata = 0;

      // response arrives during a full hold; a later stray response is ignored
      issue_a(1, 2, 0, 2'd0, 5'd9, 32'h0, 32'h400);
      tick();
      nop_a(); a_stall = 6'b011111; a_rvalid = 1; a_rdata = 32'h55AA_0FF0; #1;
      chk("hold_sreq", a_sreq, 0);
      tick();
      a_rvalid = 1; a_rdata = 32'h1111_1111; #1;
      chk("hold_buf", a_wb_wdata, 32'h55AA_0FF0);
      tick();
      a_rvalid = 0; a_rdata = 0; a_stall = 0; #1;
      chk("hold_wdata", a_wb_wdata, 32'h55AA_0FF0);
      chk("hold_valid", a_wb_valid, 1);
      chk("hold_we", a_wb_we, 1);
      tick();

      // ALU op then bubble
      issue_a(0, 0, 0, 2'd0, 5'd3, 32'h1234, 32'h500);
      a_hwe = 1; a_hilo = 64'hAAAA_BBBB_CCCC_DDDD;
      tick();
      nop_a(); #1;
      chk("alu_wdata", a_wb_wdata, 32'h1234);
      chk("alu_hilo", a_wb_hilo, 64'hAAAA_BBBB_CCCC_DDDD);
      chk("alu_hwe", a_wb_hwe, 1);
      issue_a(0, 0, 0, 2'd0, 5'd4, 32'h9999, 32'h504);
      a_stall = 6'b001000;
      tick();
      #1;
      chk("bub_valid", a_wb_valid, 0);
      chk("bub_pc", a_wb_pc, 0);
      chk("bub_we", a_wb_we, 0);
      chk("bub_waddr", a_wb_waddr, 0);
      chk("bub_wdata", a_wb_wdata, 0);
      chk("bub_hwe", a_wb_hwe, 0);
      chk("bub_hilo", a_wb_hilo, 0);
      chk("bub_fwd", {a_f_we, a_f_waddr, a_f_wdata, a_f_hwe, a_f_hilo}, 0);
      nop_a(); a_stall = 0;
      tick();

      // reset while waiting abandons the load
      issue_a(1, 2, 0, 2'd0, 5'd10, 32'h0, 32'h600);
      tick();
      nop_a(); #1;
      chk("rw_sreq", a_sreq, 1);
      rst = 0;
      tick();
      rst = 1; a_rvalid = 1; a_rdata = 32'hDEAD_BEEF; #1;
      chk("rw_valid", a_wb_valid, 0);
      chk("rw_sreq_after", a_sreq, 0);
      chk("rw_wdata", a_wb_wdata, 0);
      tick();
      a_rvalid = 0; a_rdata = 0; #1;
      chk("rw_valid2", a_wb_valid, 0);

      // 64-bit datapath: dword, upper word, hilo pass-through
      b_valid = 1; b_ld = 1; b_size = 3; b_sgn = 1; b_addr = 0; b_we = 1; b_waddr = 2;
      b_rdata = 64'h8000_0000_0000_0001; b_rvalid = 1;
      tick();
      nop_b(); b_rvalid = 0; b_rdata = 0; #1;
      chk("ld64_wdata", b_wb_wdata, 64'h8000_0000_0000_0001);
      chk("ld64_mis", b_mis, 0);
      b_valid = 1; b_ld = 1; b_size = 2; b_sgn = 1; b_addr = 3'd4; b_we = 1; b_waddr = 3;
      b_rdata = 64'h8765_4321_0000_0000; b_rvalid = 1;
      tick();
      nop_b(); b_rvalid = 0; b_rdata = 0; #1;
      chk("lw64_wdata", b_wb_wdata, 64'hFFFF_FFFF_8765_4321);
      b_valid = 1; b_hwe = 1; b_hilo = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      b_exr = 64'h77;
      tick();
      nop_b(); #1;
      chk("hilo64", b_wb_hilo, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      chk("hilo64_fwd", b_f_hilo, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      chk("hilo64_we", b_wb_hwe, 1);
      chk("exr64", b_wb_wdata, 64'h77);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
